// File: rtl/nibble_alu_sequencer_if.sv
// Request/response bundle between the issue logic and the nibble ALU sequencer.
// The issue side holds the master modport; the sequencer holds the slave modport.
interface nibble_alu_sequencer_if #(
    parameter int P_XLEN = 32
);
    logic              req_val;
    logic              req_rdy;
    logic [2:0]        req_op;
    logic [P_XLEN-1:0] req_a;
    logic [P_XLEN-1:0] req_b;
    logic              resp_val;
    logic              resp_rdy;
    logic [P_XLEN-1:0] resp_result;
    logic              resp_carry;
    logic              resp_ne;

    modport master (
        output req_val, req_op, req_a, req_b, resp_rdy,
        input  req_rdy, resp_val, resp_result, resp_carry, resp_ne
    );

    modport slave (
        input  req_val, req_op, req_a, req_b, resp_rdy,
        output req_rdy, resp_val, resp_result, resp_carry, resp_ne
    );
endinterface

// File: rtl/nibble_alu_sequencer.sv
// Nibble-serial controller for the 4-bit ALU slice: takes a full-width
// operation, feeds the slice LSB nibble first while chaining the carry, and
// returns the assembled result plus carry/inequality flags.
module nibble_alu_sequencer #(
    parameter int P_XLEN = 32,
    parameter int P_NNIB = P_XLEN / 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    nibble_alu_sequencer_if.slave        bus,
    output logic [3:0]                   alu_in_a,
    output logic [3:0]                   alu_in_b,
    output logic                         alu_in_c,
    output logic                         alu_addsub_fn,
    output logic [1:0]                   alu_logic_fn,
    input  logic [3:0]                   alu_sum,
    input  logic                         alu_carry,
    input  logic                         alu_ne,
    input  logic [3:0]                   alu_fn_out
);
    localparam int IDX_W = (P_NNIB > 1) ? $clog2(P_NNIB) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_SEQ  = 3'b111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        op;
    logic [P_XLEN-1:0] a_sh, b_sh;
    logic [P_XLEN-1:0] result;
    logic [IDX_W-1:0]  idx;
    logic              carry_reg;
    logic              ne_acc;
    logic              resp_carry_q;
    logic              is_logic, is_sub, last_nib;
    logic [3:0]        nib_in;
    logic [P_XLEN-1:0] word_shift;

    // Compare ops turn the assembled difference into a single-bit answer.
    // sa/sb are the operand sign bits, taken from the last nibble fed to the slice.
    function automatic logic [P_XLEN-1:0] finalise(
        input logic [2:0]        f_op,
        input logic [P_XLEN-1:0] word,
        input logic              carry_final,
        input logic              ne_final,
        input logic              sa,
        input logic              sb
    );
        logic [P_XLEN-1:0] r;
        r = '0;
        case (f_op)
            OP_SLTU: r[0] = ~carry_final;
            OP_SLT:  r[0] = (sa != sb) ? sa : word[P_XLEN-1];
            OP_SEQ:  r[0] = ~ne_final;
            default: r = word;
        endcase
        return r;
    endfunction

    assign is_logic   = (op == OP_XOR) || (op == OP_OR) || (op == OP_AND);
    assign is_sub     = (op == OP_SUB) || (op == OP_SLT) || (op == OP_SLTU) || (op == OP_SEQ);
    assign last_nib   = (idx == IDX_W'(P_NNIB - 1));
    assign nib_in     = is_logic ? alu_fn_out : alu_sum;
    assign word_shift = {nib_in, result[P_XLEN-1:4]};

    assign bus.resp_result = result;
    assign bus.resp_carry  = resp_carry_q;
    assign bus.resp_ne     = ne_acc;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode and slice/handshake outputs; slice inputs idle at 0 outside BUSY.
    always_comb begin
        state_next    = state;
        bus.req_rdy   = 1'b0;
        bus.resp_val  = 1'b0;
        alu_in_a      = 4'h0;
        alu_in_b      = 4'h0;
        alu_in_c      = 1'b0;
        alu_addsub_fn = 1'b0;
        alu_logic_fn  = 2'b00;
        case (state)
            IDLE: begin
                bus.req_rdy = reset_n;
                if (bus.req_val) state_next = BUSY;
            end
            BUSY: begin
                alu_in_a      = a_sh[3:0];
                alu_in_b      = b_sh[3:0];
                alu_addsub_fn = is_sub;
                alu_in_c      = (idx == '0) ? is_sub : carry_reg;
                case (op)
                    OP_OR:   alu_logic_fn = 2'b10;
                    OP_AND:  alu_logic_fn = 2'b11;
                    default: alu_logic_fn = 2'b00;
                endcase
                if (last_nib) state_next = DONE;
            end
            DONE: begin
                bus.resp_val = 1'b1;
                if (bus.resp_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, nibble walk, flag accumulation and result finalisation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op           <= OP_ADD;
            a_sh         <= '0;
            b_sh         <= '0;
            result       <= '0;
            idx          <= '0;
            carry_reg    <= 1'b0;
            ne_acc       <= 1'b0;
            resp_carry_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_val) begin
                        op        <= bus.req_op;
                        a_sh      <= bus.req_a;
                        b_sh      <= bus.req_b;
                        result    <= '0;
                        idx       <= '0;
                        carry_reg <= 1'b0;
                        ne_acc    <= 1'b0;
                    end
                end
                BUSY: begin
                    carry_reg <= alu_carry;
                    ne_acc    <= ne_acc | alu_ne;
                    a_sh      <= a_sh >> 4;
                    b_sh      <= b_sh >> 4;
                    if (last_nib) begin
                        result       <= finalise(op, word_shift, alu_carry, ne_acc | alu_ne,
                                                 a_sh[3], b_sh[3]);
                        resp_carry_q <= is_logic ? 1'b0 : alu_carry;
                    end else begin
                        result <= word_shift;
                        idx    <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_alu_sequencer.sv
// Directed bench for nibble_alu_sequencer with a behavioural 4-bit ALU slice.
module tb_nibble_alu_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nibble_alu_sequencer_if #(.P_XLEN(32)) bus ();

    logic [3:0] alu_in_a, alu_in_b, alu_sum, alu_fn_out;
    logic       alu_in_c, alu_addsub_fn, alu_carry, alu_ne;
    logic [1:0] alu_logic_fn;
    logic [4:0] slice_s;

    int compared = 0;
    int mismatched = 0;

    nibble_alu_sequencer #(.P_XLEN(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .alu_in_a      (alu_in_a),
        .alu_in_b      (alu_in_b),
        .alu_in_c      (alu_in_c),
        .alu_addsub_fn (alu_addsub_fn),
        .alu_logic_fn  (alu_logic_fn),
        .alu_sum       (alu_sum),
        .alu_carry     (alu_carry),
        .alu_ne        (alu_ne),
        .alu_fn_out    (alu_fn_out)
    );

    // Behavioural ALU slice
    always_comb begin
        slice_s   = {1'b0, alu_in_a} + {1'b0, (alu_addsub_fn ? ~alu_in_b : alu_in_b)} + {4'b0, alu_in_c};
        alu_sum   = slice_s[3:0];
        alu_carry = slice_s[4];
        alu_ne    = (alu_in_a != alu_in_b);
        case (alu_logic_fn)
            2'b10:   alu_fn_out = alu_in_a | alu_in_b;
            2'b11:   alu_fn_out = alu_in_a & alu_in_b;
            default: alu_fn_out = alu_in_a ^ alu_in_b;
        endcase
    end

    // Present a request and return at the falling edge after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_val = 1'b1;
        bus.req_op  = op;
        bus.req_a   = a;
        bus.req_b   = b;
        while (bus.req_rdy !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (bus.req_rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL issue_timeout: req_rdy=%b required 1", bus.req_rdy);
        end
        @(negedge clk);
        bus.req_val = 1'b0;
    endtask

    // Count cycles from accept to resp_val, recording per-nibble carry-in.
    task automatic wait_resp(output int lat, output logic [7:0] cmask,
                             output logic [1:0] lfn0, output logic fn0);
        lat   = 0;
        cmask = 8'h00;
        lfn0  = alu_logic_fn;
        fn0   = alu_addsub_fn;
        while (bus.resp_val !== 1'b1 && lat < 30) begin
            if (lat < 8) cmask[lat] = alu_in_c;
            @(negedge clk);
            lat++;
        end
        compared++;
        if (bus.resp_val !== 1'b1) begin
            mismatched++;
            $display("FAIL resp_timeout: resp_val=%b required 1", bus.resp_val);
        end
    endtask

    task automatic ack();
        bus.resp_rdy = 1'b1;
        @(negedge clk);
        bus.resp_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        compared++;
        if (bus.req_rdy !== 1'b0 || bus.resp_val !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_hs: req_rdy=%b resp_val=%b required 0 0", bus.req_rdy, bus.resp_val);
        end
        compared++;
        if (bus.resp_result !== 32'h0 || bus.resp_carry !== 1'b0 || bus.resp_ne !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_resp: result=%h carry=%b ne=%b required 0 0 0",
                     bus.resp_result, bus.resp_carry, bus.resp_ne);
        end
        compared++;
        if ({alu_in_a, alu_in_b, alu_in_c, alu_addsub_fn, alu_logic_fn} !== 12'h000) begin
            mismatched++;
            $display("FAIL reset_alu: a=%h b=%h c=%b fn=%b lfn=%b required all 0",
                     alu_in_a, alu_in_b, alu_in_c, alu_addsub_fn, alu_logic_fn);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        compared++;
        if (bus.req_rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL idle_rdy: req_rdy=%b required 1", bus.req_rdy);
        end
    endtask

    task automatic test_add_wrap();
        int lat; logic [7:0] cm; logic [1:0] lf; logic f0;
        issue(3'b000, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (lat !== 8) begin
            mismatched++;
            $display("FAIL add_latency: got %0d required 8", lat);
        end
        compared++;
        if (bus.resp_result !== 32'h0 || bus.resp_carry !== 1'b1 || bus.resp_ne !== 1'b1) begin
            mismatched++;
            $display("FAIL add_wrap: result=%h carry=%b ne=%b required 00000000 1 1",
                     bus.resp_result, bus.resp_carry, bus.resp_ne);
        end
        ack();
        compared++;
        if (bus.resp_val !== 1'b0 || bus.req_rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL add_ack: resp_val=%b req_rdy=%b required 0 1", bus.resp_val, bus.req_rdy);
        end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] cm; logic [1:0] lf; logic f0;
        issue(3'b001, 32'h0000_0005, 32'h0000_0007);
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'hFFFF_FFFE || bus.resp_carry !== 1'b0) begin
            mismatched++;
            $display("FAIL sub_result: result=%h carry=%b required fffffffe 0",
                     bus.resp_result, bus.resp_carry);
        end
        compared++;
        if (cm !== 8'h01 || f0 !== 1'b1) begin
            mismatched++;
            $display("FAIL sub_carry_in: cin_mask=%b addsub=%b required 00000001 1", cm, f0);
        end
        ack();
    endtask

    task automatic test_compare();
        int lat; logic [7:0] cm; logic [1:0] lf; logic f0;
        issue(3'b101, 32'h8000_0000, 32'h0000_0001);
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'h1 || bus.resp_carry !== 1'b1) begin
            mismatched++;
            $display("FAIL slt: result=%h carry=%b required 00000001 1", bus.resp_result, bus.resp_carry);
        end
        ack();
        issue(3'b110, 32'h8000_0000, 32'h0000_0001);
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'h0 || bus.resp_ne !== 1'b1) begin
            mismatched++;
            $display("FAIL sltu: result=%h ne=%b required 00000000 1", bus.resp_result, bus.resp_ne);
        end
        ack();
        issue(3'b111, 32'h1234_ABCD, 32'h1234_ABCD);
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'h1 || bus.resp_ne !== 1'b0 || bus.resp_carry !== 1'b1) begin
            mismatched++;
            $display("FAIL seq: result=%h ne=%b carry=%b required 00000001 0 1",
                     bus.resp_result, bus.resp_ne, bus.resp_carry);
        end
        ack();
    endtask

    task automatic test_logic();
        logic [2:0]  ops  [3] = '{3'b010, 3'b011, 3'b100};
        logic [31:0] exps [3] = '{32'hFF00_FFFF, 32'hFFF0_FFFF, 32'h00F0_0000};
        logic [1:0]  lfns [3] = '{2'b00, 2'b10, 2'b11};
        int lat; logic [7:0] cm; logic [1:0] lf; logic f0;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 32'hF0F0_A5A5, 32'h0FF0_5A5A);
            wait_resp(lat, cm, lf, f0);
            compared++;
            if (bus.resp_result !== exps[i] || bus.resp_carry !== 1'b0) begin
                mismatched++;
                $display("FAIL logic_result op=%0d: result=%h carry=%b required %h 0",
                         ops[i], bus.resp_result, bus.resp_carry, exps[i]);
            end
            compared++;
            if (lf !== lfns[i] || f0 !== 1'b0) begin
                mismatched++;
                $display("FAIL logic_fn op=%0d: lfn=%b addsub=%b required %b 0", ops[i], lf, f0, lfns[i]);
            end
            ack();
        end
    endtask

    task automatic test_hold();
        int lat; logic [7:0] cm; logic [1:0] lf; logic f0;
        int bad;
        issue(3'b000, 32'h1111_1111, 32'h2222_2222);
        wait_resp(lat, cm, lf, f0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.resp_val !== 1'b1 || bus.req_rdy !== 1'b0 || bus.resp_result !== 32'h3333_3333 ||
                bus.resp_carry !== 1'b0 || bus.resp_ne !== 1'b1) bad++;
        end
        compared++;
        if (bad !== 0) begin
            mismatched++;
            $display("FAIL hold_stable: %0d unstable cycles required 0 (last result=%h)", bad, bus.resp_result);
        end
        ack();
        compared++;
        if (bus.resp_val !== 1'b0 || bus.req_rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL hold_release: resp_val=%b req_rdy=%b required 0 1", bus.resp_val, bus.req_rdy);
        end
        issue(3'b010, 32'h0000_00FF, 32'h0000_000F);
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'h0000_00F0) begin
            mismatched++;
            $display("FAIL hold_second: result=%h required 000000f0", bus.resp_result);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int lat; logic [7:0] cm; logic [1:0] lf; logic f0;
        issue(3'b000, 32'h0000_000A, 32'h0000_0006);
        bus.req_val = 1'b1;
        bus.req_op  = 3'b001;
        bus.req_a   = 32'h0000_0009;
        bus.req_b   = 32'h0000_0004;
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'h0000_0010 || bus.resp_carry !== 1'b0 || lat !== 8) begin
            mismatched++;
            $display("FAIL busy_req_ignored: result=%h carry=%b lat=%0d required 00000010 0 8",
                     bus.resp_result, bus.resp_carry, lat);
        end
        ack();
        compared++;
        if (bus.req_rdy !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_rdy: req_rdy=%b required 1", bus.req_rdy);
        end
        @(negedge clk);
        bus.req_val = 1'b0;
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'h0000_0005 || lat !== 8) begin
            mismatched++;
            $display("FAIL b2b_second: result=%h lat=%0d required 00000005 8", bus.resp_result, lat);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] cm; logic [1:0] lf; logic f0;
        logic seen;
        issue(3'b000, 32'h1234_5678, 32'h1111_1111);
        repeat (3) @(negedge clk);
        compared++;
        if (alu_in_a !== 4'h5) begin
            mismatched++;
            $display("FAIL mid_nibble3: alu_in_a=%h required 5", alu_in_a);
        end
        #2 reset_n = 1'b0;
        #1;
        compared++;
        if (alu_in_a !== 4'h0 || alu_in_b !== 4'h0 || bus.resp_val !== 1'b0 || bus.req_rdy !== 1'b0 ||
            bus.resp_result !== 32'h0 || bus.resp_ne !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset: a=%h b=%h resp_val=%b req_rdy=%b result=%h ne=%b required all 0",
                     alu_in_a, alu_in_b, bus.resp_val, bus.req_rdy, bus.resp_result, bus.resp_ne);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen = seen | bus.resp_val;
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL abandoned_resp: resp_val seen=%b required 0", seen);
        end
        issue(3'b000, 32'h0000_0002, 32'h0000_0003);
        wait_resp(lat, cm, lf, f0);
        compared++;
        if (bus.resp_result !== 32'h0000_0005 || bus.resp_carry !== 1'b0 || lat !== 8) begin
            mismatched++;
            $display("FAIL post_reset_add: result=%h carry=%b lat=%0d required 00000005 0 8",
                     bus.resp_result, bus.resp_carry, lat);
        end
        ack();
    endtask

    initial begin
        bus.req_val  = 1'b0;
        bus.req_op   = 3'b000;
        bus.req_a    = 32'h0;
        bus.req_b    = 32'h0;
        bus.resp_rdy = 1'b0;
        test_reset();
        test_add_wrap();
        test_sub();
        test_compare();
        test_logic();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/nibble_alu_sequencer.md
Name: nibble_alu_sequencer

Overview:
Nibble-serial controller on the other end of the 4-bit datapath ALU slice. It accepts a 32-bit operation over a val/rdy request port and drives the slice LSB-nibble first. It chains the carry between nibbles, collects sum or logic nibbles and the slice flags, then returns the 32-bit result and flags over a val/rdy response port. It sits between the core control/issue logic and the ALU slice in the Nibbler datapath.

Parameters:
P_XLEN, 32, operand and result width; must be a multiple of 4.
P_NNIB, P_XLEN/4, nibbles per operation (derived; do not override).

Ports:
clk  input  1  core clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
req_val  input  1  request valid
req_rdy  output  1  request ready
req_op  input  3  000 ADD, 001 SUB, 010 XOR, 011 OR, 100 AND, 101 SLT, 110 SLTU, 111 SEQ
req_a  input  P_XLEN  operand A
req_b  input  P_XLEN  operand B
resp_val  output  1  response valid
resp_rdy  input  1  response ready
resp_result  output  P_XLEN  result
resp_carry  output  1  carry out of the final nibble (ADD/SUB/SLT/SLTU/SEQ); 0 for logic ops
resp_ne  output  1  1 iff A != B, accumulated over all nibbles
alu_in_a  output  4  current A nibble to the slice
alu_in_b  output  4  current B nibble to the slice
alu_in_c  output  1  carry-in to the slice
alu_addsub_fn  output  1  0 = add, 1 = subtract
alu_logic_fn  output  2  XOR = 00, OR = 10, AND = 11
alu_sum  input  4  slice sum nibble
alu_carry  input  1  slice carry out
alu_ne  input  1  slice nibble inequality flag
alu_fn_out  input  4  slice logic nibble

Behaviour:
- States: IDLE, BUSY, DONE. Reset (asynchronous, reset_n=0) forces IDLE, clears the nibble index, carry register, ne accumulator and result register, and sets req_rdy=0 during reset.
  - After reset: resp_val=0, resp_result=0, resp_carry=0, resp_ne=0, alu_* outputs=0.
- IDLE:
  - req_rdy=1, resp_val=0.
  - On req_val&req_rdy: capture op, A and B; clear idx, ne_acc and result; go to BUSY.
- BUSY:
  - req_rdy=0. Drive alu_in_a=A[4*idx+3:4*idx] and alu_in_b=B[4*idx+3:4*idx].
  - alu_addsub_fn=1 for SUB/SLT/SLTU/SEQ, else 0.
  - alu_in_c: at idx=0 it equals alu_addsub_fn; at idx>0 it equals the registered carry.
  - alu_logic_fn: 00 for XOR, 10 for OR, 11 for AND; 00 for all other ops.
  - Each edge: carry_reg<=alu_carry; ne_acc<=ne_acc|alu_ne.
  - Each edge: result shifts right 4 and the incoming nibble lands in [P_XLEN-1:P_XLEN-4]. The incoming nibble is alu_sum for ADD/SUB/SLT/SLTU/SEQ and alu_fn_out for logic ops.
  - At idx=P_NNIB-1: go to DONE; otherwise idx<=idx+1.
- DONE:
  - resp_val=1 and req_rdy=0. All resp_* outputs stay stable until resp_rdy.
  - On resp_rdy: go to IDLE. A new request is accepted at the earliest one cycle later.
- Result finalisation happens on the DONE entry edge, using the final nibble's flags.
  - ADD/SUB/logic: resp_result = assembled word.
  - SLTU: resp_result = {0, ~carry_final}.
  - SLT: let sa=A[31], sb=B[31], d=sum[31]. resp_result = {0, (sa!=sb)?sa:d}.
  - SEQ: resp_result = {0, ~ne_final}.
  - resp_ne = ne_final for every op.
  - resp_carry = carry_final for arithmetic/compare ops, 0 for logic ops.
- Timing:
  - Accept edge E0; nibbles consumed on E1..E8; resp_val high in the cycle after E8.
  - Latency from accept to resp_val is P_NNIB cycles, so a back-to-back throughput of P_NNIB+2 cycles per op with resp_rdy held high.
- Wrap-around: ADD/SUB results are modulo 2^P_XLEN. The final carry is reported, never folded into the result.
- Simultaneous events:
  - req_val while BUSY/DONE is ignored; the requester must hold it.
  - resp_rdy in IDLE/BUSY has no effect.
- Reset mid-operation: the operation is abandoned immediately, with no response. The first request after reset_n deasserts starts cleanly from idx=0.

Test Plan:
- ADD 0xFFFFFFFF + 0x00000001 -> resp_result=0x00000000, resp_carry=1, resp_ne=1. resp_val rises exactly 8 cycles after accept.
- SUB 0x00000005 - 0x00000007 -> resp_result=0xFFFFFFFE, resp_carry=0. alu_in_c=1 on nibble 0 only.
- SLT A=0x80000000, B=0x00000001 -> result 1. SLTU on the same operands -> result 0. SEQ 0x1234ABCD vs 0x1234ABCD -> result 1, resp_ne=0.
- Logic ops on A=0xF0F0A5A5, B=0x0FF05A5A:
  - XOR -> 0xFF00FFFF with alu_logic_fn=00.
  - OR -> 0xFFF0FFFF with alu_logic_fn=10.
  - AND -> 0x00F00000 with alu_logic_fn=11, resp_carry=0.
- Hold resp_rdy=0 for 5 cycles in DONE -> resp_* stable and req_rdy=0 throughout. Then resp_rdy=1 -> IDLE next cycle, and a second request is accepted. A req_val asserted during BUSY is not taken early.
- Assert reset_n=0 asynchronously at idx=3 of an ADD -> outputs clear without a clock edge and no resp_val. A subsequent ADD 2+3 returns 5.
